// File: rtl/dcim_mult_scheduler.sv
// DCIM multiplier front-end: loads ADDR_COUNT weights, then time-shares the macro compute port
// between two requesters in round-robin bursts. Define DCIM_SCHED_BURST_CAP_EN to cap beats per grant.
module dcim_mult_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int PROD_WIDTH = 64,
  parameter int ADDR_COUNT = 64,
  parameter int PIPE_LAT   = 3,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wload_valid,
  input  logic [DATA_WIDTH-1:0] wload_data,
  output logic                  wload_ready,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  output logic                  mac_pe_ce,
  output logic                  mac_init_enable,
  output logic [DATA_WIDTH-1:0] mac_data_in,
  input  logic                  mac_init_done,
  input  logic [PROD_WIDTH-1:0] mac_data_out,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_last,
  output logic [PROD_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, READY, BURST} state_t;

  localparam int CNT_W   = $clog2(ADDR_COUNT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

`ifdef DCIM_SCHED_BURST_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     word_cnt_reg, word_cnt_next;
  logic [BURST_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic                 grant_reg, grant_next;
  logic                 rr_reg, rr_next;

  logic                  beat_accept;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  other_valid;
  logic                  cap_hit;

  // Tag entry: {valid, id, last}
  logic [2:0] tag_reg [PIPE_LAT];
  logic [2:0] tag_in;
  logic       tag_any;

  assign beat_accept = (state_reg == BURST) && (grant_reg ? req1_valid : req0_valid);
  assign beat_last   = grant_reg ? req1_last : req0_last;
  assign beat_data   = grant_reg ? req1_data : req0_data;
  assign other_valid = grant_reg ? req0_valid : req1_valid;
  assign cap_hit     = CAP_EN && (beat_cnt_reg == BURST_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      beat_cnt_reg <= '0;
      grant_reg    <= 1'b0;
      rr_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
      grant_reg    <= grant_next;
      rr_reg       <= rr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    grant_next    = grant_reg;
    rr_next       = rr_reg;
    case (state_reg)
      IDLE: begin
        state_next    = LOAD;
        word_cnt_next = '0;
      end
      LOAD: begin
        if (wload_valid) begin
          word_cnt_next = word_cnt_reg + CNT_W'(1);
          if (word_cnt_reg == CNT_W'(ADDR_COUNT - 1)) state_next = WAIT;
        end
      end
      WAIT: begin
        if (mac_init_done) state_next = READY;
      end
      READY: begin
        beat_cnt_next = '0;
        if (req0_valid || req1_valid) begin
          state_next = BURST;
          grant_next = (req0_valid && req1_valid) ? rr_reg : req1_valid;
        end
      end
      BURST: begin
        if (beat_accept) begin
          if (beat_last) begin
            state_next = READY;
            rr_next    = ~grant_reg;
          end else if (cap_hit) begin
            // Cap reached: yield only if the other side is actually waiting
            beat_cnt_next = '0;
            if (other_valid) begin
              state_next = READY;
              rr_next    = ~grant_reg;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + BURST_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wload_ready     = 1'b0;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    mac_pe_ce       = 1'b0;
    mac_init_enable = 1'b0;
    mac_data_in     = '0;
    case (state_reg)
      // IDLE is also the reset state; keep the init pulse quiet while reset is held
      IDLE: begin
        mac_init_enable = rst_n;
        mac_pe_ce       = rst_n;
      end
      LOAD: begin
        wload_ready = 1'b1;
        mac_pe_ce   = wload_valid;
        mac_data_in = wload_data;
      end
      BURST: begin
        req0_ready = ~grant_reg;
        req1_ready = grant_reg;
        mac_pe_ce  = 1'b1;
        if (beat_accept) mac_data_in = beat_data;
      end
      default: ;
    endcase
  end

  assign tag_in = {beat_accept, beat_accept & grant_reg, beat_accept & beat_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) tag_any = tag_any | tag_reg[i][2];
  end

  assign rsp_valid = tag_reg[PIPE_LAT-1][2];
  assign rsp_id    = tag_reg[PIPE_LAT-1][1];
  assign rsp_last  = tag_reg[PIPE_LAT-1][0];
  assign rsp_data  = rsp_valid ? mac_data_out : '0;
  assign busy      = (state_reg != READY) || tag_any;

endmodule

// File: tb/tb_dcim_mult_scheduler.sv
// Directed bench for dcim_mult_scheduler: weight load, bursts, arbitration, valid drop, async reset.
`timescale 1ns/1ps
module tb_dcim_mult_scheduler;
  localparam int DW = 32;
  localparam int PW = 64;
  localparam int AC = 64;
  localparam int PL = 3;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wload_valid = 1'b0;
  logic [DW-1:0] wload_data = '0;
  logic          wload_ready;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_last = 1'b0, req1_last = 1'b0;
  logic          req0_ready, req1_ready;
  logic          mac_pe_ce, mac_init_enable;
  logic [DW-1:0] mac_data_in;
  logic          mac_init_done = 1'b0;
  logic [PW-1:0] mac_data_out;
  logic          rsp_valid, rsp_id, rsp_last;
  logic [PW-1:0] rsp_data;
  logic          busy;

  always #5 clk = ~clk;

  dcim_mult_scheduler #(
    .DATA_WIDTH(DW), .PROD_WIDTH(PW), .ADDR_COUNT(AC), .PIPE_LAT(PL), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wload_valid(wload_valid), .wload_data(wload_data), .wload_ready(wload_ready),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .mac_pe_ce(mac_pe_ce), .mac_init_enable(mac_init_enable), .mac_data_in(mac_data_in),
    .mac_init_done(mac_init_done), .mac_data_out(mac_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .busy(busy)
  );

  function automatic logic [PW-1:0] prod(input logic [DW-1:0] x);
    return 64'(x) * 64'd1000003 + 64'd17;
  endfunction

  // Macro model: product appears PL cycles after the operand is presented
  logic [PW-1:0] mdl [PL];
  always @(posedge clk) begin
    mdl[0] <= prod(mac_data_in);
    for (int i = 1; i < PL; i++) mdl[i] <= mdl[i-1];
  end
  assign mac_data_out = mdl[PL-1];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic          id;
    logic          last;
    logic [PW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   acc_ids[$];
  int   acc_cyc[$];
  int   exp_ids[$];
  int   exp_gaps[$];
  int   cyc = 0;
  int   word_cnt = 0;
  int   init_pulses = 0;

  logic acc0, acc1;
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      word_cnt    <= 0;
      init_pulses <= 0;
    end else begin
      if (mac_init_enable) init_pulses <= init_pulses + 1;
      if (wload_valid && wload_ready) begin
        check("load_pe_ce", 64'(mac_pe_ce), 64'd1);
        check("load_data_in", 64'(mac_data_in), 64'(word_cnt));
        word_cnt <= word_cnt + 1;
      end else if (wload_ready) begin
        check("load_stall_pe_ce", 64'(mac_pe_ce), 64'd0);
      end
      if (rsp_valid || (sb.size() > 0 && sb[0].due == cyc)) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp_cycle", 64'(cyc), 64'(sb[0].due));
          check("rsp_valid", 64'(rsp_valid), 64'd1);
          check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
          check("rsp_last", 64'(rsp_last), 64'(sb[0].last));
          check("rsp_data", rsp_data, sb[0].data);
          sb.delete(0);
        end
      end
      if (acc0 || acc1) begin
        check("one_beat_per_cycle", 64'(acc0 && acc1), 64'd0);
        check("beat_pe_ce", 64'(mac_pe_ce), 64'd1);
        check("beat_data_in", 64'(mac_data_in), 64'(acc1 ? req1_data : req0_data));
        sb.push_back('{acc1, acc1 ? req1_last : req0_last, prod(acc1 ? req1_data : req0_data), cyc + PL});
        acc_ids.push_back(acc1 ? 1 : 0);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [DW-1:0] d, input logic l);
    if (id) begin
      req1_valid = v; req1_data = d; req1_last = l;
    end else begin
      req0_valid = v; req0_data = d; req0_last = l;
    end
  endtask

  // Drives n beats; optionally drops valid for two cycles before beat drop_at
  task automatic send(input bit id, input int n, input logic [DW-1:0] base, input int drop_at);
    bit got;
    for (int k = 0; k < n; k++) begin
      if (k == drop_at) begin
        set_req(id, 1'b0, '0, 1'b0);
        for (int d = 0; d < 2; d++) begin
          @(negedge clk);
          check("drop_hold_ready", 64'(id ? req1_ready : req0_ready), 64'd1);
          check("drop_other_ready", 64'(id ? req0_ready : req1_ready), 64'd0);
          step();
        end
      end
      set_req(id, 1'b1, base + DW'(k), k == n - 1);
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = id ? req1_ready : req0_ready;
        step();
      end
      check("beat_accepted_in_time", 64'(got), 64'd1);
    end
    set_req(id, 1'b0, '0, 1'b0);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, 64'(acc_ids.size()), 64'(exp_ids.size()));
    for (int k = 0; k < acc_ids.size() && k < exp_ids.size(); k++)
      check({tag, "_id"}, 64'(acc_ids[k]), 64'(exp_ids[k]));
  endtask

  task automatic check_gaps(input string tag);
    check({tag, "_beats"}, 64'(acc_cyc.size()), 64'(exp_gaps.size() + 1));
    for (int k = 1; k < acc_cyc.size() && k <= exp_gaps.size(); k++)
      check({tag, "_gap"}, 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(exp_gaps[k-1]));
  endtask

  task automatic clear_log();
    acc_ids.delete();
    acc_cyc.delete();
  endtask

  initial begin : main
    int  nw;
    int  c;
    bit  acc;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_wload_ready", 64'(wload_ready), 64'd0);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    check("rst_pe_ce", 64'(mac_pe_ce), 64'd0);
    check("rst_init_enable", 64'(mac_init_enable), 64'd0);
    check("rst_data_in", 64'(mac_data_in), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_pulse", 64'(mac_init_enable), 64'd1);
    check("init_pe_ce", 64'(mac_pe_ce), 64'd1);
    check("init_wload_ready", 64'(wload_ready), 64'd0);
    step();

    // Weight load 0..63 with three stall cycles
    nw = 0;
    c  = 0;
    while (nw < AC && c < 400) begin
      wload_valid = !(c == 7 || c == 23 || c == 41);
      wload_data  = DW'(nw);
      @(negedge clk);
      acc = wload_valid && wload_ready;
      step();
      if (acc) nw++;
      c++;
    end
    wload_valid = 1'b1;
    wload_data  = 32'd99;
    check("load_words", 64'(nw), 64'(AC));
    check("load_stall_cycles", 64'(c), 64'(AC + 3));
    @(negedge clk);
    check("load_pe_words", 64'(word_cnt), 64'(AC));
    check("wait_wload_ready", 64'(wload_ready), 64'd0);
    check("wait_pe_ce", 64'(mac_pe_ce), 64'd0);
    check("wait_busy", 64'(busy), 64'd1);
    check("init_pulse_count", 64'(init_pulses), 64'd1);
    repeat (3) step();
    @(negedge clk);
    check("wait_hold_ready", 64'(wload_ready), 64'd0);
    check("wait_hold_busy", 64'(busy), 64'd1);
    step();
    wload_valid = 1'b0;
    mac_init_done = 1'b1;
    step();
    @(negedge clk);
    check("ready_idle_busy", 64'(busy), 64'd0);
    check("ready_no_grant", 64'(req0_ready | req1_ready), 64'd0);

    // req0 burst of 4, operands 1..4
    step();
    clear_log();
    send(1'b0, 4, 32'd1, -1);
    repeat (PL + 2) step();
    exp_ids = '{0, 0, 0, 0};
    exp_gaps = '{1, 1, 1};
    check_seq("burst4");
    check_gaps("burst4");
    check("burst4_drained", 64'(sb.size()), 64'd0);
    check("burst4_busy", 64'(busy), 64'd0);

    // req1 burst of 5 with a two-cycle valid drop before beat 3
    clear_log();
    send(1'b1, 5, 32'd50, 2);
    repeat (PL + 2) step();
    exp_ids = '{1, 1, 1, 1, 1};
    exp_gaps = '{1, 3, 1, 1};
    check_seq("drop");
    check_gaps("drop");
    check("drop_drained", 64'(sb.size()), 64'd0);

    // Both requesters continuously valid, 2-beat bursts
    clear_log();
    fork
      begin send(1'b0, 2, 32'd100, -1); send(1'b0, 2, 32'd200, -1); end
      begin send(1'b1, 2, 32'd300, -1); send(1'b1, 2, 32'd400, -1); end
    join
    repeat (PL + 2) step();
    exp_ids = '{0, 0, 1, 1, 0, 0, 1, 1};
    exp_gaps = '{1, 2, 1, 2, 1, 2, 1};
    check_seq("rr");
    check_gaps("rr");
    check("rr_drained", 64'(sb.size()), 64'd0);

    // req0 long burst of 20 while req1 waits with 2 beats
    clear_log();
    fork
      send(1'b0, 20, 32'd500, -1);
      send(1'b1, 2, 32'd600, -1);
    join
    repeat (PL + 2) step();
    exp_ids.delete();
`ifdef DCIM_SCHED_BURST_CAP_EN
    for (int k = 0; k < MB; k++) exp_ids.push_back(0);
    for (int k = 0; k < 2; k++) exp_ids.push_back(1);
    for (int k = MB; k < 20; k++) exp_ids.push_back(0);
`else
    for (int k = 0; k < 20; k++) exp_ids.push_back(0);
    for (int k = 0; k < 2; k++) exp_ids.push_back(1);
`endif
    check_seq("long");
    check("long_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with beats in flight
    clear_log();
    send(1'b0, 2, 32'd700, -1);
    check("flight_busy", 64'(busy), 64'd1);
    check("flight_rsp_pending", 64'(rsp_valid), 64'd0);
    step();
    check("flight_rsp_head", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rsp_data", rsp_data, 64'd0);
    check("async_busy", 64'(busy), 64'd1);
    check("async_init_enable", 64'(mac_init_enable), 64'd0);
    check("async_pe_ce", 64'(mac_pe_ce), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reinit_pulse", 64'(mac_init_enable), 64'd1);
    check("reinit_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (8) step();
    check("reinit_pulse_count", 64'(init_pulses), 64'd1);
    check("reinit_wload_ready", 64'(wload_ready), 64'd1);
    check("reinit_no_rsp", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcim_mult_scheduler.md
# dcim_mult_scheduler

Front-end scheduler for the DCIM SRAM multiplier macro. It loads the 64 weight words into the macro, then shares the macro's compute port between two operand requesters. Requesters are served as round-robin bursts, and each 64-bit product is routed back with its requester ID and burst-end flag. It sits between the host/NoC request ports and the macro's pe_ce / init_enable / data_in / data_out pins.

## Interface
- DATA_WIDTH, 32, operand and weight width
- PROD_WIDTH, 64, product width
- ADDR_COUNT, 64, weight words loaded per init
- PIPE_LAT, 3, cycles from operand accept to macro product valid (≥1)
- MAX_BURST, 16, beat cap per grant (used only with DCIM_SCHED_BURST_CAP_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wload_valid  in  1  weight word valid
- wload_data  in  DATA_WIDTH  weight word
- wload_ready  out  1  weight word accepted when valid&ready
- req0_valid / req1_valid  in  1  operand valid
- req0_data / req1_data  in  DATA_WIDTH  operand
- req0_last / req1_last  in  1  final beat of burst
- req0_ready / req1_ready  out  1  operand accepted when valid&ready
- mac_pe_ce  out  1  macro clock enable
- mac_init_enable  out  1  macro init request
- mac_data_in  out  DATA_WIDTH  macro data input
- mac_init_done  in  1  macro weight init complete
- mac_data_out  in  PROD_WIDTH  macro product
- rsp_valid  out  1  product valid (no backpressure)
- rsp_id  out  1  requester of product
- rsp_last  out  1  product belongs to a last beat
- rsp_data  out  PROD_WIDTH  product
- busy  out  1  state≠READY or tag pipeline non-empty

## Operation
- States: IDLE, LOAD, WAIT, READY, BURST.
- IDLE:
  - mac_init_enable=1 and mac_pe_ce=1 for exactly one cycle.
  - Next state LOAD, word count=0.
- LOAD:
  - wload_ready=1.
  - mac_pe_ce=wload_valid, mac_data_in=wload_data.
  - The count increments per accepted word.
  - After ADDR_COUNT words: wload_ready=0, go to WAIT.
  - A stall on wload_valid freezes the macro (pe_ce=0).
- WAIT: hold until mac_init_done=1, then go to READY.
- READY (arbitration):
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not served last. rr pointer resets to 0, so req0 wins the first tie.
  - A grant moves to BURST. With no requester valid, stay in READY.
- BURST:
  - req<g>_ready=1 and mac_pe_ce=1 every cycle.
  - mac_data_in=req<g>_data when the beat is accepted, else 0.
  - The non-granted ready is 0.
  - Accepting a beat with last=1 returns to READY and flips the rr pointer to the other requester.
- Tag pipeline:
  - Each accepted beat shifts {1,id,last} into a PIPE_LAT-deep shift register; non-accept cycles shift in 0.
  - Tail valid drives rsp_valid, with rsp_id/rsp_last from the tag.
  - rsp_data=mac_data_out is sampled on the same cycle.
- wload_valid after LOAD is ignored; wload_ready stays 0 until reset.
- The two requester beats are never merged; at most one beat is accepted per cycle.

## Timing
- Reset values: state=IDLE, all ready=0, mac_pe_ce=0, mac_init_enable=0, mac_data_in=0, rsp_valid=0, rsp_id=0, rsp_last=0, rsp_data=0, busy=1, rr=0, tag pipeline empty.
- Reset is asynchronous mid-operation: outputs clear immediately, and in-flight tags are dropped (no rsp).
- Init cost:
  - The first mac_init_enable pulse occurs in the first cycle after reset release.
  - LOAD takes ≥ADDR_COUNT cycles.
- READY→BURST costs one dead cycle. Back-to-back bursts therefore have one bubble between the last beat of one and the first beat of the next.
- Within a burst, one beat per cycle is accepted at full throughput.
- Beat accepted at cycle t produces rsp_valid at t+PIPE_LAT.
- rsp order equals accept order.
- req_valid dropping mid-burst keeps the grant; ready stays 1 and the pipeline takes bubbles.

## Configuration
- DCIM_SCHED_BURST_CAP_EN defined:
  - The beat counter per grant is compared against MAX_BURST.
  - After the MAX_BURST-th accepted beat without last, the grant returns to READY if the other requester is valid; otherwise the count restarts and the grant continues.
  - rsp_last still reflects the requester's own last flag.
  - The interrupted requester re-enters arbitration for its remaining beats.
- Not defined: the grant is held until last, with no cap. MAX_BURST is unused.

## Test plan
- Reset, then 64 weights 0..63 streamed with 3 random wload_valid gaps -> exactly one mac_init_enable pulse; 64 pe_ce-qualified words; wload_ready=0 after word 63; state WAIT until mac_init_done.
- Req0 only, burst of 4 (last on beat 4), operands 1,2,3,4 -> rsp_valid at accept+3 for 4 cycles; rsp_id=0; rsp_last=1 only on the 4th.
- Both requesters valid continuously, 2-beat bursts each -> grants alternate 0,1,0,1; one bubble between bursts; rsp_id sequence 0,0,1,1,0,0.
- Req1 drops valid for 2 cycles mid-burst -> grant held; 2 empty tag slots; no rsp_valid in those slots; req0_ready stays 0.
- Async reset asserted with 2 beats in flight -> rsp_valid=0 immediately; no rsp after release; new init pulse in the first post-reset cycle.
- With DCIM_SCHED_BURST_CAP_EN and MAX_BURST=16: req0 issues 20 beats while req1 is waiting -> req0 serves 16 beats, then req1 is granted; req0 resumes its 4 remaining beats later; rsp_last set only on req0 beat 20.
